// File: rtl/note_decode_scheduler.sv
// rtl/note_decode_scheduler.sv - schedules one shared mod12 divider across every slot of a MIDI burst
module note_decode_scheduler #(
  parameter int NUM_SLOTS   = 5,
  parameter int MOD_TIMEOUT = 64
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        midi_burst_ready_in,
  input  logic [2:0]                  on_msg_count_in,
  input  logic [NUM_SLOTS-1:0][20:0]  midi_burst_data_in,
  output logic                        mod_start_out,
  output logic [7:0]                  mod_note_out,
  input  logic [3:0]                  mod_val_in,
  input  logic [3:0]                  mod_oct_in,
  input  logic                        mod_done_in,
  output logic                        busy_out,
  output logic                        burst_dropped_out,
  output logic                        err_out,
  output logic                        vals_ready,
  output logic [NUM_SLOTS-1:0][3:0]   octave_count,
  output logic [NUM_SLOTS-1:0][7:0]   note_value_array,
  output logic [NUM_SLOTS-1:0][7:0]   note_velocity_array
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int              TW      = (MOD_TIMEOUT > 1) ? $clog2(MOD_TIMEOUT) : 1;
  localparam logic [TW-1:0]   T_LAST  = TW'(MOD_TIMEOUT - 1);
  localparam logic [2:0]      CNT_MAX = 3'(NUM_SLOTS);

  logic [1:0]                 state;
  logic [NUM_SLOTS-1:0][7:0]  notes;
  logic [2:0]                 cnt;
  logic [2:0]                 idx;
  logic [TW-1:0]              tcnt;

  logic [2:0] cnt_clamped;
  logic       slot_end;
  logic       last_slot;

  assign cnt_clamped = (on_msg_count_in > CNT_MAX) ? CNT_MAX : on_msg_count_in;
  // A slot finishes on done or on its last permitted wait cycle; done takes priority for data.
  assign slot_end    = (state == WAIT) && (mod_done_in || (tcnt == T_LAST));
  assign last_slot   = (idx == cnt - 3'd1);

  assign mod_start_out = (state == ISSUE);
  assign mod_note_out  = ((state == ISSUE) || (state == WAIT)) ? notes[idx] : 8'd0;
  assign busy_out      = (state != IDLE);
  assign vals_ready    = (state == DONE);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state               <= IDLE;
      notes               <= '0;
      cnt                 <= 3'd0;
      idx                 <= 3'd0;
      tcnt                <= '0;
      burst_dropped_out   <= 1'b0;
      err_out             <= 1'b0;
      octave_count        <= '0;
      note_value_array    <= '0;
      note_velocity_array <= '0;
    end else begin
      burst_dropped_out <= midi_burst_ready_in && (state != IDLE);
      case (state)
        IDLE: begin
          if (midi_burst_ready_in) begin
            cnt     <= cnt_clamped;
            idx     <= 3'd0;
            tcnt    <= '0;
            err_out <= 1'b0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
              notes[s]               <= midi_burst_data_in[s][15:8];
              note_velocity_array[s] <= (3'(s) < cnt_clamped) ? midi_burst_data_in[s][7:0] : 8'd0;
              note_value_array[s]    <= 8'd0;
              octave_count[s]        <= 4'd0;
            end
            state <= (cnt_clamped != 3'd0) ? ISSUE : DONE;
          end
        end
        ISSUE: begin
          tcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          tcnt <= tcnt + TW'(1);
          if (mod_done_in) begin
            note_value_array[idx] <= {4'b0, mod_val_in};
            octave_count[idx]     <= mod_oct_in;
          end else if (tcnt == T_LAST) begin
            note_value_array[idx] <= 8'd0;
            octave_count[idx]     <= 4'd0;
            err_out               <= 1'b1;
          end
          if (slot_end) begin
            if (last_slot) begin
              state <= DONE;
            end else begin
              idx   <= idx + 3'd1;
              state <= ISSUE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_decode_scheduler.sv
// tb/tb_note_decode_scheduler.sv - directed self-checking bench for note_decode_scheduler
module tb_note_decode_scheduler;
  localparam int N = 5;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              midi_burst_ready_in;
  logic [2:0]        on_msg_count_in;
  logic [N-1:0][20:0] midi_burst_data_in;
  logic              mod_start_out;
  logic [7:0]        mod_note_out;
  logic [3:0]        mod_val_in;
  logic [3:0]        mod_oct_in;
  logic              mod_done_in;
  logic              busy_out;
  logic              burst_dropped_out;
  logic              err_out;
  logic              vals_ready;
  logic [N-1:0][3:0] octave_count;
  logic [N-1:0][7:0] note_value_array;
  logic [N-1:0][7:0] note_velocity_array;

  int vectors = 0;
  int miscompares = 0;
  int lat_cfg = 4;
  int skip_idx = -1;
  int start_ord = 0;
  int starts = 0;
  int cd = 0;
  int lat;
  int seen;
  logic [7:0] held = 8'd0;

  note_decode_scheduler #(.NUM_SLOTS(N), .MOD_TIMEOUT(64)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .midi_burst_ready_in(midi_burst_ready_in), .on_msg_count_in(on_msg_count_in),
    .midi_burst_data_in(midi_burst_data_in),
    .mod_start_out(mod_start_out), .mod_note_out(mod_note_out),
    .mod_val_in(mod_val_in), .mod_oct_in(mod_oct_in), .mod_done_in(mod_done_in),
    .busy_out(busy_out), .burst_dropped_out(burst_dropped_out), .err_out(err_out),
    .vals_ready(vals_ready), .octave_count(octave_count),
    .note_value_array(note_value_array), .note_velocity_array(note_velocity_array)
  );

  always #5 clk_in = ~clk_in;

  // mod12 model: done is sampled lat_cfg cycles after the start cycle; skip_idx never answers
  always @(negedge clk_in) begin
    if (mod_start_out) begin
      starts++;
      held = mod_note_out;
      mod_done_in = 1'b0;
      cd = (start_ord != skip_idx) ? lat_cfg : 0;
      start_ord++;
    end else if (cd > 0) begin
      cd--;
      mod_done_in = (cd == 0);
      mod_val_in  = 4'(held % 12);
      mod_oct_in  = 4'(held / 12);
    end else begin
      mod_done_in = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [N-1:0][7:0] nts, input logic [N-1:0][7:0] vls);
    for (int s = 0; s < N; s++) midi_burst_data_in[s] = {5'h15, nts[s], vls[s]};
  endtask

  task automatic start_burst(input logic [2:0] c);
    @(negedge clk_in);
    starts = 0;
    start_ord = 0;
    on_msg_count_in = c;
    midi_burst_ready_in = 1'b1;
    @(negedge clk_in);
    midi_burst_ready_in = 1'b0;
  endtask

  task automatic wait_ready(output int l);
    l = 1;
    while (!vals_ready && l < 2000) begin
      @(negedge clk_in);
      l++;
    end
  endtask

  task automatic check_arrays(input string tag, input logic [39:0] en, input logic [19:0] eo,
                              input logic [39:0] ev);
    chk({tag, "_note"}, 64'(note_value_array), 64'(en));
    chk({tag, "_oct"},  64'(octave_count), 64'(eo));
    chk({tag, "_vel"},  64'(note_velocity_array), 64'(ev));
  endtask

  initial begin
    rst_in = 1'b1;
    midi_burst_ready_in = 1'b0;
    on_msg_count_in = 3'd0;
    midi_burst_data_in = '0;
    mod_val_in = 4'd0;
    mod_oct_in = 4'd0;
    mod_done_in = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("rst_busy", 64'(busy_out), 64'd0);
    chk("rst_flags", 64'({vals_ready, err_out, burst_dropped_out, mod_start_out}), 64'd0);
    chk("rst_modnote", 64'(mod_note_out), 64'd0);
    check_arrays("rst", 40'd0, 20'd0, 40'd0);
    rst_in = 1'b0;

    // basic: notes 60,69,127,0,12 (slot 0 rightmost)
    lat_cfg = 4;
    load({8'd12, 8'd0, 8'd127, 8'd69, 8'd60}, {8'd50, 8'd40, 8'd30, 8'd20, 8'd10});
    start_burst(3'd5);
    wait_ready(lat);
    chk("basic_lat", 64'(lat), 64'd26);
    chk("basic_starts", 64'(starts), 64'd5);
    chk("basic_err", 64'(err_out), 64'd0);
    check_arrays("basic", {8'd0, 8'd0, 8'd7, 8'd9, 8'd0}, {4'd1, 4'd0, 4'd10, 4'd5, 4'd5},
                 {8'd50, 8'd40, 8'd30, 8'd20, 8'd10});
    @(negedge clk_in);
    chk("basic_after", 64'({busy_out, vals_ready}), 64'd0);

    // cnt = 0
    load({8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, {8'd9, 8'd8, 8'd7, 8'd6, 8'd5});
    start_burst(3'd0);
    wait_ready(lat);
    chk("zero_lat", 64'(lat), 64'd1);
    chk("zero_starts", 64'(starts), 64'd0);
    check_arrays("zero", 40'd0, 20'd0, 40'd0);

    // cnt = 7 clamps to 5
    load({8'd100, 8'd50, 8'd25, 8'd13, 8'd1}, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
    start_burst(3'd7);
    wait_ready(lat);
    chk("clamp_lat", 64'(lat), 64'd26);
    chk("clamp_starts", 64'(starts), 64'd5);
    check_arrays("clamp", {8'd4, 8'd2, 8'd1, 8'd1, 8'd1}, {4'd8, 4'd4, 4'd2, 4'd1, 4'd0},
                 {8'd5, 8'd4, 8'd3, 8'd2, 8'd1});

    // cnt = 2, L = 2
    lat_cfg = 2;
    load({8'd92, 8'd91, 8'd90, 8'd45, 8'd30}, {8'd55, 8'd44, 8'd33, 8'd22, 8'd11});
    start_burst(3'd2);
    wait_ready(lat);
    chk("part_lat", 64'(lat), 64'd7);
    chk("part_starts", 64'(starts), 64'd2);
    check_arrays("part", {8'd0, 8'd0, 8'd0, 8'd9, 8'd6}, {4'd0, 4'd0, 4'd0, 4'd3, 4'd2},
                 {8'd0, 8'd0, 8'd0, 8'd22, 8'd11});

    // timeout on slot 1
    lat_cfg = 4;
    skip_idx = 1;
    load({8'd3, 8'd2, 8'd71, 8'd35, 8'd24}, {8'd1, 8'd1, 8'd9, 8'd8, 8'd7});
    start_burst(3'd3);
    wait_ready(lat);
    chk("tmo_lat", 64'(lat), 64'd76);
    chk("tmo_starts", 64'(starts), 64'd3);
    chk("tmo_err", 64'(err_out), 64'd1);
    check_arrays("tmo", {8'd0, 8'd0, 8'd11, 8'd0, 8'd0}, {4'd0, 4'd0, 4'd5, 4'd0, 4'd2},
                 {8'd0, 8'd0, 8'd9, 8'd8, 8'd7});
    skip_idx = -1;
    load({8'd0, 8'd0, 8'd0, 8'd0, 8'd12}, {8'd0, 8'd0, 8'd0, 8'd0, 8'd99});
    start_burst(3'd1);
    chk("tmo_err_clr", 64'(err_out), 64'd0);
    wait_ready(lat);
    chk("next_lat", 64'(lat), 64'd6);
    check_arrays("next", 40'd0, {16'd0, 4'd1}, {32'd0, 8'd99});

    // collision: second strobe while in WAIT
    load({8'd0, 8'd0, 8'd0, 8'd61, 8'd60}, {8'd0, 8'd0, 8'd0, 8'd6, 8'd5});
    start_burst(3'd2);
    @(negedge clk_in);
    load({8'd1, 8'd1, 8'd1, 8'd1, 8'd1}, {8'd77, 8'd77, 8'd77, 8'd77, 8'd77});
    on_msg_count_in = 3'd5;
    midi_burst_ready_in = 1'b1;
    @(negedge clk_in);
    midi_burst_ready_in = 1'b0;
    chk("coll_drop", 64'(burst_dropped_out), 64'd1);
    @(negedge clk_in);
    chk("coll_drop_end", 64'(burst_dropped_out), 64'd0);
    wait_ready(lat);
    chk("coll_ready", 64'(vals_ready), 64'd1);
    chk("coll_starts", 64'(starts), 64'd2);
    check_arrays("coll", {8'd0, 8'd0, 8'd0, 8'd1, 8'd0}, {4'd0, 4'd0, 4'd0, 4'd5, 4'd5},
                 {8'd0, 8'd0, 8'd0, 8'd6, 8'd5});

    // reset while waiting on slot 0
    load({8'd0, 8'd0, 8'd127, 8'd69, 8'd60}, {8'd0, 8'd0, 8'd3, 8'd2, 8'd1});
    start_burst(3'd3);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    chk("wrst_busy", 64'(busy_out), 64'd0);
    chk("wrst_flags", 64'({vals_ready, err_out, burst_dropped_out, mod_start_out}), 64'd0);
    check_arrays("wrst", 40'd0, 20'd0, 40'd0);
    seen = 0;
    repeat (12) begin
      @(negedge clk_in);
      if (vals_ready || busy_out || mod_start_out) seen++;
    end
    chk("wrst_quiet", 64'(seen), 64'd0);
    check_arrays("wrst_late", 40'd0, 20'd0, 40'd0);
    lat_cfg = 3;
    load({8'd0, 8'd0, 8'd0, 8'd0, 8'd69}, {8'd0, 8'd0, 8'd0, 8'd0, 8'd77});
    start_burst(3'd1);
    wait_ready(lat);
    chk("post_lat", 64'(lat), 64'd5);
    check_arrays("post", {32'd0, 8'd9}, {16'd0, 4'd5}, {32'd0, 8'd77});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
